// File: rtl/hgcal_input_pkg.sv
// Shared constants for the HGCAL autoencoder input quantiser: the 2-bit cell codes,
// the default energy thresholds and the packed frame width.
package hgcal_input_pkg;

   localparam int CODE_BW = 2;

   typedef logic [CODE_BW-1:0] code_t;

   localparam code_t CODE_ZERO = 2'd0;
   localparam code_t CODE_LOW  = 2'd1;
   localparam code_t CODE_MID  = 2'd2;
   localparam code_t CODE_SAT  = 2'd3;

   localparam int unsigned DEF_T1 = 16;
   localparam int unsigned DEF_T2 = 64;
   localparam int unsigned DEF_T3 = 256;

   function automatic int frame_bw(input int num_cells);
      return num_cells * CODE_BW;
   endfunction

endpackage

// File: rtl/hgcal_cell_quantizer.sv
// Combinational 4-level quantiser: one unsigned energy word to a 2-bit code
// using three fixed thresholds (T1 < T2 < T3).
module hgcal_cell_quantizer
   import hgcal_input_pkg::*;
#(
   parameter int          IN_BW = 16,
   parameter int unsigned T1    = DEF_T1,
   parameter int unsigned T2    = DEF_T2,
   parameter int unsigned T3    = DEF_T3
) (
   input  logic [IN_BW-1:0] data,
   output code_t            code
);

   localparam logic [IN_BW-1:0] TH1 = IN_BW'(T1);
   localparam logic [IN_BW-1:0] TH2 = IN_BW'(T2);
   localparam logic [IN_BW-1:0] TH3 = IN_BW'(T3);

   // NOTE: every path through the if/else chain assigns code, so no latch is inferred.
   always_comb begin
      if (data >= TH3)      code = CODE_SAT;
      else if (data >= TH2) code = CODE_MID;
      else if (data >= TH1) code = CODE_LOW;
      else                  code = CODE_ZERO;
   end

endmodule

// File: rtl/hgcal_input_quantizer.sv
// Quantises a stream of cell energies into 2-bit codes and assembles them into a
// packed frame vector for the first LogicNets layer; S1 -> fill buffer -> output register.
module hgcal_input_quantizer
   import hgcal_input_pkg::*;
#(
   parameter int          NUM_CELLS = 48,
   parameter int          IN_BW     = 16,
   parameter int unsigned T1        = DEF_T1,
   parameter int unsigned T2        = DEF_T2,
   parameter int unsigned T3        = DEF_T3
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             s_valid,
   output logic                             s_ready,
   input  logic [IN_BW-1:0]                 s_data,
   input  logic                             s_last,
   output logic                             m_valid,
   input  logic                             m_ready,
   output logic [frame_bw(NUM_CELLS)-1:0]   m_data,
   output logic                             frame_err
);

   localparam int                IDX_BW   = $clog2(NUM_CELLS);
   localparam int                FRAME_BW = frame_bw(NUM_CELLS);
   localparam logic [IDX_BW-1:0] LAST_IDX = IDX_BW'(NUM_CELLS - 1);

   code_t               cell_code;
   logic [IDX_BW-1:0]   idx;
   logic                s1_valid;
   code_t               s1_code;
   logic [IDX_BW-1:0]   s1_idx;
   logic                s1_last;
   logic [FRAME_BW-1:0] fill_buf;
   logic [FRAME_BW-1:0] fill_nxt;
   logic                fill_done;
   logic                accept;
   logic                transfer;
   logic                s1_adv;
   logic                s1_done;
   logic                s1_mismatch;

   hgcal_cell_quantizer #(
      .IN_BW (IN_BW),
      .T1    (T1),
      .T2    (T2),
      .T3    (T3)
   ) u_cell_quantizer (
      .data (s_data),
      .code (cell_code)
   );

   assign s_ready     = !(s1_valid && fill_done);
   assign accept      = s_valid && s_ready;
   assign transfer    = fill_done && (!m_valid || m_ready);
   assign s1_adv      = s1_valid && (!fill_done || transfer);
   assign s1_done     = s1_last || (s1_idx == LAST_IDX);
   // A frame ends on either condition; only one of them alone is a length error.
   assign s1_mismatch = s1_last != (s1_idx == LAST_IDX);

   // Clearing on transfer comes first so a same-cycle S1 write lands in the fresh frame.
   always_comb begin
      fill_nxt = transfer ? '0 : fill_buf;
      if (s1_adv) fill_nxt[int'(s1_idx)*CODE_BW +: CODE_BW] = s1_code;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx       <= '0;
         s1_valid  <= 1'b0;
         s1_code   <= CODE_ZERO;
         s1_idx    <= '0;
         s1_last   <= 1'b0;
         // NOTE: the fill buffer is reset because untouched slots of a short frame must read as zero.
         fill_buf  <= '0;
         fill_done <= 1'b0;
         m_valid   <= 1'b0;
         m_data    <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= s1_adv && s1_mismatch;

         if (accept) begin
            s1_valid <= 1'b1;
            s1_code  <= cell_code;
            s1_idx   <= idx;
            s1_last  <= s_last;
            idx      <= (s_last || idx == LAST_IDX) ? '0 : idx + 1'b1;
         end else if (s1_adv) begin
            s1_valid <= 1'b0;
         end

         fill_buf <= fill_nxt;

         if (s1_adv && s1_done) fill_done <= 1'b1;
         else if (transfer)     fill_done <= 1'b0;

         if (transfer) begin
            m_valid <= 1'b1;
            m_data  <= fill_buf;
         end else if (m_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_hgcal_input_quantizer.sv
// Directed bench for hgcal_input_quantizer: hand-computed frames for quantisation,
// latency, backpressure, frame-length errors and mid-frame reset.
module tb_hgcal_input_quantizer;

   localparam int NUM_CELLS = 48;
   localparam int IN_BW     = 16;
   localparam int FB        = NUM_CELLS * 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             s_valid = 1'b0;
   logic             s_ready;
   logic [IN_BW-1:0] s_data = '0;
   logic             s_last = 1'b0;
   logic             m_valid;
   logic             m_ready = 1'b0;
   logic [FB-1:0]    m_data;
   logic             frame_err;

   int tests = 0;
   int fails = 0;
   int stall_cycles = 0;
   int err_pulses = 0;
   int err0;

   logic [FB-1:0]    got_q[$];
   logic [IN_BW-1:0] vals[NUM_CELLS];

   localparam logic [FB-1:0] F_BASIC = 96'h39;
   localparam logic [FB-1:0] F_BOUND = 96'h39E4;
   localparam logic [FB-1:0] F_ONES  = {48{2'b01}};
   localparam logic [FB-1:0] F_TWOS  = {48{2'b10}};
   localparam logic [FB-1:0] F_SATS  = {48{2'b11}};
   localparam logic [FB-1:0] F_EARLY = 96'h3F_FFFF;
   localparam logic [FB-1:0] F_C0SAT = 96'h3;
   localparam logic [FB-1:0] F_C47   = 96'hC000_0000_0000_0000_0000_0000;
   localparam logic [FB-1:0] F_C0MID = 96'h2;
   localparam logic [FB-1:0] F_C5LOW = 96'h400;

   always #5 clk = ~clk;

   hgcal_input_quantizer #(
      .NUM_CELLS (NUM_CELLS),
      .IN_BW     (IN_BW),
      .T1        (16),
      .T2        (64),
      .T3        (256)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .frame_err (frame_err)
   );

   // Output monitor sampled mid-cycle: completed handshakes and frame_err pulses.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (frame_err === 1'b1) err_pulses++;
         if (m_valid === 1'b1 && m_ready === 1'b1) got_q.push_back(m_data);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [FB-1:0] obs, input logic [FB-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic checkn(input string tag, input int obs, input int exp);
      tests++;
      assert (obs == exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic idle();
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = '0;
   endtask

   // Present one beat and hold it until accepted (bounded).
   task automatic beat(input logic [IN_BW-1:0] d, input logic l);
      bit taken;
      taken   = 1'b0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      for (int n = 0; n < 200 && !taken; n++) begin
         taken = (s_ready === 1'b1);
         if (!taken) stall_cycles++;
         tick();
      end
      if (!taken) checkn("beat_timeout", 0, 1);
   endtask

   task automatic clear_vals();
      for (int i = 0; i < NUM_CELLS; i++) vals[i] = '0;
   endtask

   task automatic send_frame(input int n, input bit with_last);
      for (int i = 0; i < n; i++) beat(vals[i], with_last && (i == n - 1));
   endtask

   task automatic wait_frames(input string tag, input int n);
      for (int k = 0; k < 200 && got_q.size() < n; k++) tick();
      checkn(tag, got_q.size(), n);
   endtask

   task automatic expect_frame(input string tag, input logic [FB-1:0] exp);
      if (got_q.size() > 0) check(tag, got_q.pop_front(), exp);
      else                  check(tag, 'x, exp);
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check1("reset_s_ready", s_ready, 1'b1);
      check1("reset_m_valid", m_valid, 1'b0);
      check("reset_m_data", m_data, '0);
      check1("reset_frame_err", frame_err, 1'b0);

      // All-zero frame: exact latency, s_ready never drops
      m_ready = 1'b1;
      err0 = err_pulses;
      stall_cycles = 0;
      clear_vals();
      send_frame(NUM_CELLS, 1'b1);
      idle();
      check1("lat_t0_m_valid", m_valid, 1'b0);
      tick();
      check1("lat_t1_m_valid", m_valid, 1'b0);
      tick();
      check1("lat_t2_m_valid", m_valid, 1'b1);
      check("zero_frame_data", m_data, '0);
      tick();
      check1("m_valid_drops", m_valid, 1'b0);
      checkn("zero_frame_stalls", stall_cycles, 0);
      checkn("zero_frame_err", err_pulses - err0, 0);
      expect_frame("zero_frame_captured", '0);

      // Basic quantisation, then threshold boundaries
      clear_vals();
      vals[0] = 16'd20;
      vals[1] = 16'd100;
      vals[2] = 16'd300;
      send_frame(NUM_CELLS, 1'b1);
      clear_vals();
      vals[0] = 16'd15;
      vals[1] = 16'd16;
      vals[2] = 16'd255;
      vals[3] = 16'd256;
      vals[4] = 16'd63;
      vals[5] = 16'd64;
      vals[6] = 16'hFFFF;
      send_frame(NUM_CELLS, 1'b1);
      idle();
      wait_frames("quant_count", 2);
      expect_frame("quant_basic", F_BASIC);
      expect_frame("quant_boundary", F_BOUND);

      // Backpressure: three frames with m_ready low
      m_ready = 1'b0;
      for (int i = 0; i < NUM_CELLS; i++) beat(16'd20, i == NUM_CELLS - 1);
      for (int i = 0; i < NUM_CELLS; i++) beat(16'd100, i == NUM_CELLS - 1);
      beat(16'd300, 1'b0);
      check1("bp_s_ready_low", s_ready, 1'b0);
      check1("bp_m_valid", m_valid, 1'b1);
      check("bp_m_data_f1", m_data, F_ONES);
      s_data = 16'd300;
      tick();
      tick();
      tick();
      check1("bp_s_ready_held", s_ready, 1'b0);
      check("bp_m_data_stable", m_data, F_ONES);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      check("bp_m_data_f2", m_data, F_TWOS);
      check1("bp_m_valid_f2", m_valid, 1'b1);
      check1("bp_s_ready_rise", s_ready, 1'b1);
      for (int i = 1; i < NUM_CELLS; i++) beat(16'd300, i == NUM_CELLS - 1);
      idle();
      tick();
      tick();
      check("bp_f2_held", m_data, F_TWOS);
      m_ready = 1'b1;
      tick();
      check("bp_m_data_f3", m_data, F_SATS);
      tick();
      check1("bp_drain_m_valid", m_valid, 1'b0);
      expect_frame("bp_q_f1", F_ONES);
      expect_frame("bp_q_f2", F_TWOS);
      expect_frame("bp_q_f3", F_SATS);

      // Early s_last on cell 10, then a normal frame restarting at index 0
      err0 = err_pulses;
      for (int i = 0; i <= 10; i++) beat(16'd1000, i == 10);
      idle();
      check1("early_err_pre", frame_err, 1'b0);
      tick();
      check1("early_err_pulse", frame_err, 1'b1);
      tick();
      check1("early_err_one_cycle", frame_err, 1'b0);
      check1("early_m_valid", m_valid, 1'b1);
      check("early_m_data", m_data, F_EARLY);
      clear_vals();
      vals[0] = 16'd300;
      send_frame(NUM_CELLS, 1'b1);
      idle();
      wait_frames("early_count", 2);
      expect_frame("early_q_frame", F_EARLY);
      expect_frame("early_next_frame", F_C0SAT);
      checkn("early_err_total", err_pulses - err0, 1);

      // Missing s_last on a full frame, followed by a correct frame
      err0 = err_pulses;
      clear_vals();
      vals[NUM_CELLS-1] = 16'd300;
      send_frame(NUM_CELLS, 1'b0);
      clear_vals();
      vals[0] = 16'd100;
      send_frame(NUM_CELLS, 1'b1);
      idle();
      wait_frames("nolast_count", 2);
      expect_frame("nolast_first", F_C47);
      expect_frame("nolast_second", F_C0MID);
      checkn("nolast_err_total", err_pulses - err0, 1);

      // Reset mid-frame: partial data discarded, no error
      for (int i = 0; i < 20; i++) beat(16'd300, 1'b0);
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check1("midrst_m_valid", m_valid, 1'b0);
      check1("midrst_s_ready", s_ready, 1'b1);
      check1("midrst_frame_err", frame_err, 1'b0);
      err0 = err_pulses;
      clear_vals();
      vals[5] = 16'd20;
      send_frame(NUM_CELLS, 1'b1);
      idle();
      wait_frames("midrst_count", 1);
      expect_frame("midrst_frame", F_C5LOW);
      for (int i = 0; i < 10; i++) tick();
      checkn("midrst_no_extra", got_q.size(), 0);
      checkn("midrst_err", err_pulses - err0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
